// File: rtl/paper_ctrl_pkg.sv
// Shared encodings for the paper processor control path: states, opcodes,
// ALU operations and PC source selects.
package paper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_e;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_JMP   = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_ADDR = 2'd2;
    localparam logic [1:0] ALU_CMP  = 2'd3;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    function automatic logic [1:0] alu_op_of(input logic [2:0] op);
        logic [1:0] res;
        case (op)
            OP_ADD:            res = ALU_ADD;
            OP_SUB:            res = ALU_SUB;
            OP_LOAD, OP_STORE: res = ALU_ADDR;
            OP_BEQ:            res = ALU_CMP;
            default:           res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/paper_ctrl_if.sv
// Control/datapath/memory signal bundle for paper_ctrl. The controller uses
// the master modport; the datapath and memory side use the slave modport.
interface paper_ctrl_if #(parameter int OP_W = 3);
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic            addr_sel;
    logic            ir_en;
    logic            pc_en;
    logic [1:0]      pc_src;
    logic [1:0]      alu_op;
    logic            rf_we;
    logic            wb_sel;
    logic            halted;
    logic [2:0]      state;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src,
               alu_op, rf_we, wb_sel, halted, state
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src,
               alu_op, rf_we, wb_sel, halted, state
    );
endinterface

// File: rtl/paper_ctrl_perf.sv
// Cycle and retired-instruction counters for paper_ctrl; only instantiated
// when PAPER_CTRL_PERF_EN is defined. Both wrap modulo 2^CNT_W.
module paper_ctrl_perf
    import paper_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  state_e           state_s,
    input  logic             instr_done_s,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // Counter registers: cycles while running, and each completed decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= {CNT_W{1'b0}};
            instr_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((state_s != ST_IDLE) && (state_s != ST_HALT)) begin
                cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (instr_done_s) begin
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/paper_ctrl.sv
// Multi-cycle control FSM for the paper processor. Define PAPER_CTRL_PERF_EN
// to add the cycle_cnt/instr_cnt performance counters.
module paper_ctrl
    import paper_pkg::*;
#(
    parameter int OP_W = 3
`ifdef PAPER_CTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             r,
    paper_ctrl_if.master     bus
`ifdef PAPER_CTRL_PERF_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e          state_r;
    state_e          next_s;
    logic [OP_W-1:0] op_r;
    logic            mem_req_s;
    logic            mem_we_s;
    logic            addr_sel_s;
    logic            ir_en_s;
    logic            pc_en_s;
    logic [1:0]      pc_src_s;
    logic [1:0]      alu_op_s;
    logic            rf_we_s;
    logic            wb_sel_s;
    logic            halted_s;

    // State and latched-opcode registers
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_r <= ST_IDLE;
            op_r    <= OP_W'(OP_NOP);
        end else begin
            state_r <= next_s;
            if (state_r == ST_DECODE) begin
                op_r <= bus.opcode;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        next_s     = state_r;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = 1'b0;
        ir_en_s    = 1'b0;
        pc_en_s    = 1'b0;
        pc_src_s   = PC_INC;
        alu_op_s   = ALU_ADD;
        rf_we_s    = 1'b0;
        wb_sel_s   = 1'b0;
        halted_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_s = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (bus.mem_ack) begin
                    ir_en_s = 1'b1;
                    pc_en_s = 1'b1;
                    next_s  = ST_DECODE;
                end else begin
                    next_s  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (bus.opcode == OP_W'(OP_HALT)) begin
                    next_s = ST_HALT;
                end else if (bus.opcode == OP_W'(OP_NOP)) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op_s = alu_op_of(3'(op_r));
                if ((op_r == OP_W'(OP_ADD)) || (op_r == OP_W'(OP_SUB))) begin
                    next_s = ST_WB;
                end else if ((op_r == OP_W'(OP_LOAD)) || (op_r == OP_W'(OP_STORE))) begin
                    next_s = ST_MEM;
                end else if (op_r == OP_W'(OP_BEQ)) begin
                    pc_en_s  = bus.zero;
                    pc_src_s = bus.zero ? PC_BRANCH : PC_INC;
                    next_s   = ST_FETCH;
                end else if (op_r == OP_W'(OP_JMP)) begin
                    pc_en_s  = 1'b1;
                    pc_src_s = PC_JUMP;
                    next_s   = ST_FETCH;
                end else begin
                    next_s   = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (op_r == OP_W'(OP_STORE));
                alu_op_s   = ALU_ADDR;
                if (!bus.mem_ack) begin
                    next_s = ST_MEM;
                end else if (op_r == OP_W'(OP_LOAD)) begin
                    next_s = ST_WB;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_WB: begin
                rf_we_s  = 1'b1;
                wb_sel_s = (op_r == OP_W'(OP_LOAD));
                next_s   = ST_FETCH;
            end
            ST_HALT: begin
                halted_s = 1'b1;
                next_s   = ST_HALT;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.mem_we   = mem_we_s;
    assign bus.addr_sel = addr_sel_s;
    assign bus.ir_en    = ir_en_s;
    assign bus.pc_en    = pc_en_s;
    assign bus.pc_src   = pc_src_s;
    assign bus.alu_op   = alu_op_s;
    assign bus.rf_we    = rf_we_s;
    assign bus.wb_sel   = wb_sel_s;
    assign bus.halted   = halted_s;
    assign bus.state    = state_r;

`ifdef PAPER_CTRL_PERF_EN
    logic instr_done_s;
    assign instr_done_s = (state_r == ST_DECODE) && (next_s != ST_HALT);

    paper_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst_n        (r),
        .state_s      (state_r),
        .instr_done_s (instr_done_s),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_paper_ctrl.sv
// Directed bench for paper_ctrl: each instruction is expanded into a
// cycle-by-cycle schedule of stimulus and expected strobes.
module tb_paper_ctrl;

    logic clk;
    logic r;
    paper_ctrl_if #(.OP_W(3)) bus ();

`ifdef PAPER_CTRL_PERF_EN
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;
    paper_ctrl #(.OP_W(3)) dut (.clk(clk), .r(r), .bus(bus),
                                .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    paper_ctrl #(.OP_W(3)) dut (.clk(clk), .r(r), .bus(bus));
`endif

    typedef struct packed {
        logic       rn;
        logic       ack;
        logic       zero;
        logic [2:0] opc;
        logic [2:0] st;
        logic       req, we, asel, ir, pc;
        logic [1:0] psrc, alu;
        logic       rf, wb, hlt;
    } cyc_t;

    cyc_t sched[$];
    cyc_t expq[$];
    int   lat_q[$];
    int   meas[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycles from one FETCH entry to the next with no memory wait.
    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd3: return 4;
            3'd2:             return 5;
            3'd4, 3'd5:       return 3;
            3'd6:             return 2;
            default:          return 0;
        endcase
    endfunction

    // A cycle with noise on every input the DUT should ignore there.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.rn = 1'b1; c.st = st; c.ack = 1'b1; c.zero = 1'b1; c.opc = 3'd7;
        return c;
    endfunction

    task automatic add_reset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = '0;
            c.ack = 1'b1; c.opc = 3'd7;
            sched.push_back(c);
        end
        sched.push_back(mk(3'd0));
    endtask

    task automatic plan(input logic [2:0] op, input logic z, input int fw, input int mw, input bit cut);
        cyc_t c;
        for (int i = 0; i < fw; i++) begin
            c = mk(3'd1); c.req = 1'b1; c.ack = 1'b0; sched.push_back(c);
        end
        c = mk(3'd1); c.req = 1'b1; c.ir = 1'b1; c.pc = 1'b1; sched.push_back(c);
        c = mk(3'd2); c.opc = op; sched.push_back(c);
        if (op == 3'd7) begin
            for (int i = 0; i < 10; i++) begin
                c = mk(3'd6); c.hlt = 1'b1; c.opc = i[2:0]; c.ack = i[0]; c.zero = ~i[0];
                sched.push_back(c);
            end
            return;
        end
        if (op != 3'd6) begin
            c = mk(3'd3);
            case (op)
                3'd0: c.alu = 2'd0;
                3'd1: c.alu = 2'd1;
                3'd2, 3'd3: c.alu = 2'd2;
                3'd4: begin c.alu = 2'd3; c.zero = z; c.pc = z; c.psrc = z ? 2'd1 : 2'd0; end
                3'd5: begin c.pc = 1'b1; c.psrc = 2'd2; end
                default: c.alu = 2'd0;
            endcase
            sched.push_back(c);
            if (op == 3'd2 || op == 3'd3) begin
                for (int i = 0; i <= mw; i++) begin
                    c = mk(3'd4); c.req = 1'b1; c.asel = 1'b1; c.alu = 2'd2;
                    c.we = (op == 3'd3); c.ack = (i == mw);
                    if (cut && i == mw) return;
                    sched.push_back(c);
                end
            end
            if (op <= 3'd2) begin
                c = mk(3'd5); c.rf = 1'b1; c.wb = (op == 3'd2); sched.push_back(c);
            end
        end
        lat_q.push_back(lat_of(op) + fw + mw);
    endtask

    // Compare process: every cycle, DUT outputs against the scheduled expectation.
    int         since = 0;
    bit         have_prev = 1'b0;
    logic [2:0] last_st = 3'd0;
    cyc_t       prev_e = '0;
    int         m_cyc = 0;
    int         m_ins = 0;
    always @(negedge clk) begin
        cyc_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("state",    int'(bus.state),    int'(e.st));
            chk("mem_req",  int'(bus.mem_req),  int'(e.req));
            chk("mem_we",   int'(bus.mem_we),   int'(e.we));
            chk("addr_sel", int'(bus.addr_sel), int'(e.asel));
            chk("ir_en",    int'(bus.ir_en),    int'(e.ir));
            chk("pc_en",    int'(bus.pc_en),    int'(e.pc));
            chk("pc_src",   int'(bus.pc_src),   int'(e.psrc));
            chk("alu_op",   int'(bus.alu_op),   int'(e.alu));
            chk("rf_we",    int'(bus.rf_we),    int'(e.rf));
            chk("wb_sel",   int'(bus.wb_sel),   int'(e.wb));
            chk("halted",   int'(bus.halted),   int'(e.hlt));
`ifdef PAPER_CTRL_PERF_EN
            if (!e.rn) begin
                m_cyc = 0; m_ins = 0;
            end else if (prev_e.rn) begin
                if (prev_e.st != 3'd0 && prev_e.st != 3'd6) m_cyc = (m_cyc + 1) % 65536;
                if (prev_e.st == 3'd2 && e.st != 3'd6) m_ins = (m_ins + 1) % 65536;
            end
            chk("cycle_cnt", int'(cycle_cnt), m_cyc);
            chk("instr_cnt", int'(instr_cnt), m_ins);
`endif
            prev_e = e;
            if (bus.state == 3'd0) have_prev = 1'b0;
            if (bus.state == 3'd1 && last_st != 3'd1) begin
                if (have_prev) begin
                    if (lat_q.size() == 0) chk("latency_queue", 1, 0);
                    else chk("latency", since, lat_q.pop_front());
                    meas.push_back(since);
                end
                have_prev = 1'b1;
                since = 0;
            end
            since++;
            last_st = bus.state;
        end
    end

    // Stimulus: program the schedule, then replay it one cycle at a time.
    initial begin
        r = 1'b0; bus.opcode = 3'd7; bus.zero = 1'b0; bus.mem_ack = 1'b0;
        add_reset(3);
        plan(3'd0, 1'b0, 0, 0, 1'b0);   // ADD
        plan(3'd1, 1'b0, 2, 0, 1'b0);   // SUB, fetch waits 2
        plan(3'd2, 1'b0, 0, 3, 1'b0);   // LOAD, memory waits 3
        plan(3'd3, 1'b0, 0, 0, 1'b0);   // STORE
        plan(3'd4, 1'b1, 0, 0, 1'b0);   // BEQ taken
        plan(3'd4, 1'b0, 0, 0, 1'b0);   // BEQ not taken
        plan(3'd5, 1'b0, 0, 0, 1'b0);   // JMP
        plan(3'd6, 1'b0, 0, 0, 1'b0);   // NOP
        plan(3'd2, 1'b0, 0, 0, 1'b0);   // LOAD
        plan(3'd3, 1'b0, 0, 2, 1'b1);   // STORE cut by reset mid-MEM
        add_reset(1);
        plan(3'd0, 1'b0, 0, 0, 1'b0);   // ADD
        plan(3'd6, 1'b0, 0, 0, 1'b0);   // NOP
        plan(3'd7, 1'b0, 0, 0, 1'b0);   // HALT
        add_reset(2);

        @(posedge clk); #1;
        while (sched.size() != 0) begin
            cyc_t c;
            c = sched.pop_front();
            r = c.rn; bus.mem_ack = c.ack; bus.zero = c.zero; bus.opcode = c.opc;
            expq.push_back(c);
            @(posedge clk); #1;
        end
        @(negedge clk); #1;

        chk("latency_left", lat_q.size(), 0);
        chk("meas_count", meas.size(), 11);
        if (meas.size() >= 8) begin
            chk("add_cycles",  meas[0], 4);
            chk("sub_wait2",   meas[1], 6);
            chk("load_wait3",  meas[2], 8);
            chk("store_cycles", meas[3], 4);
            chk("beq_taken",   meas[4], 3);
            chk("beq_not",     meas[5], 3);
            chk("nop_cycles",  meas[7], 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paper_ctrl.md
Name: paper_ctrl

Overview:
Multi-cycle control FSM for the paper processor. It sequences fetch, decode, execute, memory and writeback, and drives the enables of the datapath's flip-flop registers (PC, IR, register file) plus a single shared memory port with a req/ack handshake. It sits beside the datapath, consumes opcode and zero flag, and produces all load/select strobes.

Parameters:
OP_W, 3, opcode width
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  input  1  clock; all state updates on posedge
r  input  1  asynchronous active-low reset
opcode  input  OP_W  opcode field from IR; valid during DECODE
zero  input  1  ALU zero flag; valid during EXEC
mem_ack  input  1  memory completes current request this cycle
mem_req  output  1  memory request; held until ack
mem_we  output  1  1 = store, 0 = read; valid with mem_req
addr_sel  output  1  0 = PC drives address, 1 = ALU result
ir_en  output  1  load IR this posedge
pc_en  output  1  load PC this posedge
pc_src  output  2  0 = PC+1, 1 = branch target, 2 = jump target
alu_op  output  2  0 = ADD, 1 = SUB, 2 = address add, 3 = compare
rf_we  output  1  register file write enable
wb_sel  output  1  0 = ALU result, 1 = memory data
halted  output  1  core stopped
state  output  3  current state, for debug

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 LOAD, 3 STORE, 4 BEQ, 5 JMP, 6 NOP, 7 HALT.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is illegal and goes to IDLE on the next posedge.
- Reset: r low forces, immediately and asynchronously, state=IDLE, op register=NOP, and every output to 0. This includes mem_req dropping mid-transaction. Reset release takes effect at the next posedge.
- IDLE -> FETCH unconditionally.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. If mem_ack: ir_en=1, pc_en=1, pc_src=0, go to DECODE. Otherwise stay, holding all outputs.
- DECODE: latch opcode into internal op register. HALT -> HALT; NOP -> FETCH; anything else -> EXEC.
- EXEC: alu_op is from op (ADD 0, SUB 1, LOAD/STORE 2, BEQ 3).
  - ADD/SUB -> WB.
  - LOAD/STORE -> MEM.
  - BEQ: if zero, pc_en=1 and pc_src=1; then -> FETCH.
  - JMP: pc_en=1, pc_src=2, -> FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=(op==STORE), alu_op=2 held. On mem_ack, LOAD -> WB and STORE -> FETCH; otherwise stay.
- WB: rf_we=1, wb_sel=(op==LOAD), -> FETCH.
- HALT: halted=1 and all other strobes are 0. Only r exits this state.
- ir_en, pc_en, rf_we, mem_req, mem_we, addr_sel, pc_src and wb_sel are combinational from state, op, mem_ack and zero. state and the op register are flops.
- mem_ack is ignored outside FETCH and MEM. zero is ignored outside EXEC with op BEQ.
- Latency with zero-wait memory, in cycles from FETCH entry to the next FETCH entry: ADD/SUB 4, LOAD 5, STORE 4, BEQ/JMP 3, NOP 2. Each cycle of ack delay adds one.
- The opcode input may change after DECODE without effect.

Optional Feature:
PAPER_CTRL_PERF_EN: when defined, adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W].
- Both clear on reset.
- cycle_cnt increments every posedge while state != IDLE and != HALT.
- instr_cnt increments on each DECODE->{EXEC,FETCH} transition, so HALT is not counted.
- Both wrap modulo 2^CNT_W.
When undefined, the ports and logic are absent; the FSM is identical in both builds.

Decomposition:
- Package paper_pkg holds state encodings, opcode constants, alu_op constants and pc_src constants.
- One sub-module, paper_ctrl_perf, holds the two counters and is instantiated only under PAPER_CTRL_PERF_EN.
- Next-state and output decode stay in paper_ctrl.

Test Plan:
- Reset: hold r=0 across 3 posedges, then release -> all outputs 0 and state=0 during reset; state=1 and mem_req=1 one posedge after release.
- ADD with mem_ack tied 1, opcode=0 -> states 1,2,3,5,1; rf_we=1 and wb_sel=0 only in WB; alu_op=0 in EXEC.
- LOAD with mem_ack delayed 3 cycles in MEM -> mem_req, addr_sel=1 and mem_we=0 held for 4 cycles; then WB with wb_sel=1; total 8 cycles FETCH to FETCH.
- BEQ taken and not taken:
  - zero=1 in EXEC -> pc_en=1, pc_src=1.
  - zero=0 -> pc_en=0.
  - Both return to FETCH after 3 cycles.
- HALT, then opcode and mem_ack toggled for 10 cycles -> halted=1, state=6, all strobes 0. With PERF_EN, instr_cnt is frozen and excludes HALT.
- Reset mid-MEM of a STORE: r falls between edges -> mem_req and mem_we fall immediately, no rf_we pulse, and the restart fetches via IDLE->FETCH.
